// File: rtl/sfifo_level_pkg.sv
// sfifo_level_pkg -- constants and helpers shared by the synchronous FIFO
// family (sfifo_level, sfifo_ram).
//
// Contents:
//   FIFO_WIDTH_DEF / FIFO_ABITS_DEF / FIFO_AEMPTY_DEF : default geometry
//   fifo_lvl_width(abits) : width of pointers/level for 2**abits entries
package sfifo_level_pkg;

    localparam int unsigned FIFO_WIDTH_DEF  = 18;
    localparam int unsigned FIFO_ABITS_DEF  = 4;
    localparam int unsigned FIFO_AEMPTY_DEF = 2;

    // One extra bit so the level can represent a completely full FIFO and
    // so the pointers can tell full from empty when their indices match.
    function automatic int unsigned fifo_lvl_width(input int unsigned abits);
        return abits + 1;
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram -- simple dual-port storage, WIDTH x 2**ABITS, synchronous write,
// registered read.
//
// Optional macro: SFIFO_FWFT_EN adds byp_i, which makes the read register take
// the write data instead of the array (write into an empty FIFO).
//
// Ports:
//   clk_i, reset_ni       clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i   write port
//   rd_en_i/rd_addr_i     read port; rd_data_o updates on the rd_en_i edge
//   byp_i                 (FWFT only) load read register from wr_data_i
//   rd_data_o             registered read data, held between reads
module sfifo_ram
    import sfifo_level_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned ABITS = FIFO_ABITS_DEF
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wr_en_i,
    input  logic [ABITS-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [ABITS-1:0] rd_addr_i,
`ifdef SFIFO_FWFT_EN
    input  logic             byp_i,
`endif
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ABITS];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
`ifdef SFIFO_FWFT_EN
            rd_data_q <= byp_i ? wr_data_i : mem_q[rd_addr_i];
`else
            rd_data_q <= mem_q[rd_addr_i];
`endif
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sfifo_level.sv
// sfifo_level -- synchronous FIFO with occupancy level, full/empty,
// almost-full/almost-empty flags and sticky overflow/underflow.
//
// Optional macro: SFIFO_FWFT_EN selects first-word-fall-through; the output
// register then counts as one storage slot (capacity DEPTH+1).
//
// Ports:
//   clk_i, reset_ni        clock, async active-low reset
//   clear_i                synchronous flush (pointers, level, sticky flags)
//   wr_en_i, wr_data_i     write request/data
//   rd_en_i, rd_data_o     read request/data
//   full_o, empty_o        level at capacity / zero
//   afull_o, aempty_o      level >= AFULL / level <= AEMPTY
//   level_o                registered occupancy
//   overflow_o, underflow_o sticky error flags
module sfifo_level
    import sfifo_level_pkg::*;
#(
    parameter int unsigned WIDTH  = FIFO_WIDTH_DEF,
    parameter int unsigned ABITS  = FIFO_ABITS_DEF,
    parameter int unsigned AFULL  = (2 ** ABITS) - 2,
    parameter int unsigned AEMPTY = FIFO_AEMPTY_DEF
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             afull_o,
    output logic             aempty_o,
    output logic [ABITS:0]   level_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned DEPTH = 2 ** ABITS;
    localparam int unsigned LW    = fifo_lvl_width(ABITS);
`ifdef SFIFO_FWFT_EN
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH + 1);
`else
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
`endif
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          rd_acc, wr_acc, ram_rd;

    assign full_o      = (level_q == FULL_L);
    assign empty_o     = (level_q == '0);
    assign afull_o     = (level_q >= AFULL_L);
    assign aempty_o    = (level_q <= AEMPTY_L);
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

    // clear_i wins over both requests; gating here also keeps rd_data_o frozen.
    assign rd_acc = rd_en_i && !empty_o && !clear_i;
    assign wr_acc = wr_en_i && (!full_o || rd_acc) && !clear_i;

`ifdef SFIFO_FWFT_EN
    logic out_vld_q, out_vld_d, ram_empty;

    // The RAM read register is the visible head. Refill it whenever it is
    // empty or being popped; with nothing in the array the incoming write
    // is bypassed straight into it (the array slot is consumed the same edge).
    assign ram_empty = (wptr_q == rptr_q);
    assign ram_rd    = !clear_i && (!out_vld_q || rd_acc) && (!ram_empty || wr_acc);

    always_comb begin
        out_vld_d = out_vld_q;
        if (clear_i) begin
            out_vld_d = 1'b0;
        end else if (ram_rd) begin
            out_vld_d = 1'b1;
        end else if (rd_acc) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
        end
    end
`else
    assign ram_rd = rd_acc;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ONE_L;
            if (ram_rd) rptr_d = rptr_q + ONE_L;
            if (wr_acc && !rd_acc) begin
                level_d = level_q + ONE_L;
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - ONE_L;
            end
            if (wr_en_i && full_o && !rd_acc) ovf_d = 1'b1;
            if (rd_en_i && empty_o) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    sfifo_ram #(
        .WIDTH(WIDTH),
        .ABITS(ABITS)
    ) u_ram (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_en_i  (wr_acc),
        .wr_addr_i(wptr_q[ABITS-1:0]),
        .wr_data_i(wr_data_i),
        .rd_en_i  (ram_rd),
        .rd_addr_i(rptr_q[ABITS-1:0]),
`ifdef SFIFO_FWFT_EN
        .byp_i    (ram_empty),
`endif
        .rd_data_o(rd_data_o)
    );

endmodule

// File: tb/tb_sfifo_level.sv
// tb_sfifo_level -- directed bench for sfifo_level (WIDTH=18, ABITS=4).
// Stimulus pushes expected read words into exp_q; the monitor pops and
// compares whenever the DUT accepts a read. Works with or without
// SFIFO_FWFT_EN (capacity and read timing follow the macro).
module tb_sfifo_level;

    localparam int W      = 18;
    localparam int AB     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 2;
`ifdef SFIFO_FWFT_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = DEPTH;
`endif

    logic          clk_i    = 1'b0;
    logic          reset_ni = 1'b0;
    logic          clear_i  = 1'b0;
    logic          wr_en_i  = 1'b0;
    logic          rd_en_i  = 1'b0;
    logic [W-1:0]  wr_data_i = '0;
    logic [W-1:0]  rd_data_o;
    logic          full_o, empty_o, afull_o, aempty_o, overflow_o, underflow_o;
    logic [AB:0]   level_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_q[$];
    logic [W-1:0] exp_q[$];
    int           m_lvl = 0;
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;
    logic [W-1:0] m_vis = '0;

    always #5 clk_i = ~clk_i;

    sfifo_level #(.WIDTH(W), .ABITS(AB)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .clear_i    (clear_i),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd_en_i),
        .rd_data_o  (rd_data_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .afull_o    (afull_o),
        .aempty_o   (aempty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_stat(input string nm);
        chk({nm, ".level"},  32'(level_o),  32'(m_lvl));
        chk({nm, ".full"},   32'(full_o),   32'(m_lvl == CAP));
        chk({nm, ".empty"},  32'(empty_o),  32'(m_lvl == 0));
        chk({nm, ".afull"},  32'(afull_o),  32'(m_lvl >= AFULL));
        chk({nm, ".aempty"}, 32'(aempty_o), 32'(m_lvl <= AEMPTY));
        chk({nm, ".ovf"},    32'(overflow_o),  32'(m_ovf));
        chk({nm, ".udf"},    32'(underflow_o), 32'(m_udf));
        chk({nm, ".rdata"},  32'(rd_data_o),   32'(m_vis));
    endtask

    // Starts and ends just after a falling edge; one rising edge in between.
    task automatic op(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
        bit racc, wacc;
        wr_en_i   = wr;
        wr_data_i = d;
        rd_en_i   = rd;
        clear_i   = clr;
        racc = rd && (m_lvl > 0) && !clr;
        wacc = wr && !clr && ((m_lvl < CAP) || racc);
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (racc) begin
                exp_q.push_back(m_q[0]);
`ifndef SFIFO_FWFT_EN
                m_vis = m_q[0];
`endif
                void'(m_q.pop_front());
            end
            if (wacc) m_q.push_back(d);
            if (wr && (m_lvl == CAP) && !racc) m_ovf = 1'b1;
            if (rd && (m_lvl == 0)) m_udf = 1'b1;
`ifdef SFIFO_FWFT_EN
            if (m_q.size() > 0) m_vis = m_q[0];
`endif
        end
        m_lvl = m_q.size();
        @(posedge clk_i);
        @(negedge clk_i);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_lvl = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_vis = '0;
    endtask

    // Scoreboard monitor: compare each word the DUT hands out on an accepted read.
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk_i);
            if (reset_ni && !clear_i && rd_en_i && !empty_o) begin
`ifndef SFIFO_FWFT_EN
                #1;
`endif
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_rdata: unexpected read word %0h, expected none", rd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data_o !== e) begin
                        n_err++;
                        $display("FAIL sb_rdata: got %0h, expected %0h", rd_data_o, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset values while held in reset
        #2;
        model_reset();
        chk_stat("reset");
        chk("reset.empty_k", 32'(empty_o), 32'd1);
        chk("reset.level_k", 32'(level_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // fill to capacity, then one write too many
        for (int i = 0; i < CAP; i++) begin
            op(1'b1, W'(32'h20000 + i), 1'b0, 1'b0);
            chk_stat("fill");
        end
        chk("fill.full_k",  32'(full_o),  32'd1);
        chk("fill.level_k", 32'(level_o), 32'(CAP));
        op(1'b1, 18'h3FFFF, 1'b0, 1'b0);
        chk("ovf.flag_k",  32'(overflow_o), 32'd1);
        chk("ovf.level_k", 32'(level_o),    32'(CAP));
        chk_stat("ovf");

        // drain in order, then one read too many
        for (int i = 0; i < CAP; i++) begin
            op(1'b0, '0, 1'b1, 1'b0);
            chk_stat("drain");
        end
        chk("drain.empty_k", 32'(empty_o),   32'd1);
        chk("drain.last_k",  32'(rd_data_o), 32'h20000 + CAP - 1);
        op(1'b0, '0, 1'b1, 1'b0);
        chk("udf.flag_k",  32'(underflow_o), 32'd1);
        chk("udf.hold_k",  32'(rd_data_o),   32'h20000 + CAP - 1);
        chk_stat("udf");
        op(1'b0, '0, 1'b0, 1'b1);
        chk("clr.flags_k", 32'({overflow_o, underflow_o}), 32'd0);

        // wrap-around at constant level 3
        for (int i = 0; i < 3; i++) op(1'b1, W'(32'h10000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            op(1'b1, W'(32'h15000 + i), 1'b1, 1'b0);
            chk("wrap.level_k", 32'(level_o), 32'd3);
        end
        chk_stat("wrap");

        // simultaneous read+write at full
        for (int i = 0; i < CAP - 3; i++) op(1'b1, W'(32'h2A000 + i), 1'b0, 1'b0);
        chk("bfull.pre_k", 32'(full_o), 32'd1);
        op(1'b1, 18'h2BEEF, 1'b1, 1'b0);
        chk("bfull.level_k", 32'(level_o),    32'(CAP));
        chk("bfull.full_k",  32'(full_o),     32'd1);
        chk("bfull.ovf_k",   32'(overflow_o), 32'd0);
        chk_stat("bfull");

        // simultaneous read+write at empty
        for (int i = 0; i < CAP; i++) op(1'b0, '0, 1'b1, 1'b0);
        chk("bempty.pre_k", 32'(empty_o), 32'd1);
        op(1'b1, 18'h01234, 1'b1, 1'b0);
        chk("bempty.level_k", 32'(level_o),     32'd1);
        chk("bempty.udf_k",   32'(underflow_o), 32'd1);
        chk_stat("bempty");

        // flush at level 9 with both requests active
        for (int i = 0; i < 8; i++) op(1'b1, W'(32'h30000 + i), 1'b0, 1'b0);
        chk("flush.pre_k", 32'(level_o), 32'd9);
        op(1'b1, 18'h3C3C3, 1'b1, 1'b1);
        chk("flush.level_k", 32'(level_o), 32'd0);
        chk("flush.flags_k", 32'({overflow_o, underflow_o, full_o, empty_o}), 32'd1);
        chk_stat("flush");

        // reset mid-operation at level 5
        for (int i = 0; i < 6; i++) op(1'b1, W'(32'h0E000 + i), 1'b0, 1'b0);
        op(1'b0, '0, 1'b1, 1'b0);
        chk("rstmid.pre_k", 32'(level_o), 32'd5);
        reset_ni = 1'b0;
        model_reset();
        #1;
        chk("rstmid.level_k", 32'(level_o), 32'd0);
        chk("rstmid.rdata_k", 32'(rd_data_o), 32'd0);
        chk("rstmid.flags_k",
            32'({empty_o, aempty_o, full_o, afull_o, overflow_o, underflow_o}), 32'b110000);
        chk_stat("rstmid");
        #2;
        reset_ni = 1'b1;
        op(1'b1, 18'h0ABCD, 1'b0, 1'b0);
        chk("rstwr.level_k", 32'(level_o), 32'd1);
        op(1'b0, '0, 1'b1, 1'b0);
        chk_stat("rstwr");

`ifdef SFIFO_FWFT_EN
        // head word visible without any read; thresholds while filling
        op(1'b1, 18'h2A5A5, 1'b0, 1'b0);
        chk("fwft.head_k", 32'(rd_data_o), 32'h2A5A5);
        chk_stat("fwft");
        for (int i = 1; i < CAP; i++) begin
            op(1'b1, W'(32'h11000 + i), 1'b0, 1'b0);
            chk("fwft.hold_k", 32'(rd_data_o), 32'h2A5A5);
            chk_stat("fwft_fill");
        end
        chk("fwft.full_k", 32'(full_o), 32'd1);
`endif

        repeat (3) @(negedge clk_i);
        chk("sb.leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sfifo_level.md
SFIFO_LEVEL -- requirements
Module: sfifo_level

Interface
REQ-001 SHALL have parameter WIDTH, default 18, giving the data word width in bits.
REQ-002 SHALL have parameter ABITS, default 4, giving DEPTH = 2**ABITS entries.
REQ-003 SHALL have parameter AFULL, default DEPTH-2, as the almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY, default 2, as the almost-empty threshold in entries.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous flush.
REQ-008 SHALL have port wr_en_i, input, 1 bit: write request.
REQ-009 SHALL have port wr_data_i, input, WIDTH bits: write data.
REQ-010 SHALL have port rd_en_i, input, 1 bit: read request.
REQ-011 SHALL have port rd_data_o, output, WIDTH bits: read data.
REQ-012 SHALL have ports full_o and empty_o, outputs, 1 bit each: the full and empty flags.
REQ-013 SHALL have ports afull_o and aempty_o, outputs, 1 bit each: the almost-full and almost-empty flags.
REQ-014 SHALL have port level_o, output, ABITS+1 bits: the current occupancy.
REQ-015 SHALL have ports overflow_o and underflow_o, outputs, 1 bit each: sticky error flags.

Function
REQ-016 SHALL accept a write when wr_en_i=1 and (full_o=0 or a read is accepted in the same cycle).
REQ-017 SHALL accept a read when rd_en_i=1 and empty_o=0.
REQ-018 SHALL use ABITS+1-bit read/write pointers that wrap modulo 2*DEPTH; the RAM index SHALL be the low ABITS bits.
REQ-019 SHALL update level_o one cycle after each accepted operation: +1 on write only, -1 on read only, unchanged on both.
REQ-020 SHALL derive flags from the registered level: full_o = level==DEPTH, empty_o = level==0, afull_o = level>=AFULL, aempty_o = level<=AEMPTY.
REQ-021 SHALL, on simultaneous read and write while full, accept both and keep full_o=1.
REQ-022 SHALL, on simultaneous read and write while empty, accept only the write and set underflow_o.
REQ-023 SHALL ignore a write to a full FIFO with no accepted read, and set overflow_o (sticky).
REQ-024 SHALL ignore a read while empty, and set underflow_o (sticky).
REQ-025 SHALL, in the default mode, present the read word on rd_data_o one cycle after the accepting rd_en_i edge, and hold it until the next accepted read.
REQ-026 SHALL, on clear_i=1, zero the pointers, level_o, overflow_o and underflow_o on that edge; clear_i overrides any rd_en_i or wr_en_i in the same cycle.
REQ-027 SHALL not alter rd_data_o on clear_i.

Reset
REQ-028 SHALL, while reset_ni=0, asynchronously force the pointers and level_o to 0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, overflow_o=0, underflow_o=0 and rd_data_o=0.
REQ-029 SHALL discard all stored contents when reset is asserted mid-operation, and accept writes on the first rising edge after reset_ni rises.

Configuration
REQ-030 SHALL, with macro SFIFO_FWFT_EN defined, operate first-word-fall-through: rd_data_o shows the head entry within one cycle of empty_o falling, and rd_en_i pops the head.
REQ-031 SHALL, with SFIFO_FWFT_EN defined, count the output register in level_o, so DEPTH+1 words are storable and full_o = level==DEPTH+1.
REQ-032 SHALL, without SFIFO_FWFT_EN, behave as in REQ-025 with zero added logic.

Structure
REQ-033 SHALL take its shared FIFO constants and the level/threshold width function from the common fifo package/header used by the afifo family.
REQ-034 SHALL place storage in one sub-module, sfifo_ram: simple dual-port, synchronous write, registered read, WIDTH x DEPTH.

Verification
REQ-035 SHALL verify fill: with WIDTH=18 and ABITS=4, 16 writes -> full_o=1 and level_o=16; a 17th write -> overflow_o=1 and level_o stays 16.
REQ-036 SHALL verify drain: read 16 words -> data equals the written sequence in order, then empty_o=1; a further read -> underflow_o=1.
REQ-037 SHALL verify wrap-around: 40 interleaved write/read pairs at level 3 -> no data corruption and level_o constant at 3.
REQ-038 SHALL verify simultaneous operations: both at full -> level 16 held; both at empty -> level 1 with underflow_o=1.
REQ-039 SHALL verify flush and reset: clear_i at level 9 with wr_en_i=1 -> level 0, flags cleared; reset_ni pulsed low at level 5 -> all REQ-028 values immediately.
REQ-040 SHALL verify FWFT: with SFIFO_FWFT_EN, write 0x2A5A5 -> rd_data_o=0x2A5A5 before any rd_en_i, and afull_o/aempty_o change exactly at AFULL/AEMPTY.
